grey_decoder_nbit_pipe: RTL and testbench

GREY_DECODER_NBIT_PIPE -- requirements
Module: grey_decoder_nbit_pipe

---
 rtl/grey_decoder_nbit_pipe.sv | 93 +++++++++
 tb/tb_grey_decoder_nbit_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/grey_decoder_nbit_pipe.sv
// Gray-to-binary decoder with a one-entry ready/valid output register and a
// step tracker that classifies each accepted sample against the previous one.
module grey_decoder_nbit_pipe #(
  parameter int n = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [n-1:0] i_grey,
  output logic         o_ready,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [n-1:0] o_bin,
  output logic [1:0]   o_dir,
  output logic         o_step_err,
  output logic         o_err_sticky,
  input  logic         i_clr
);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t       state;
  logic [n-1:0] prev;
  logic [n-1:0] bin_cur;
  logic [n-1:0] bin_prev;
  logic         accept;
  logic [1:0]   dir_next;
  logic         err_next;

  function automatic logic [n-1:0] g2b(input logic [n-1:0] g);
    logic [n-1:0] b;
    b[n-1] = g[n-1];
    for (int unsigned k = 1; k < n; k++)
      b[n-1-k] = b[n-k] ^ g[n-1-k];
    return b;
  endfunction

  assign bin_cur  = g2b(i_grey);
  assign bin_prev = g2b(prev);
  // i_clr blocks acceptance so the clear always wins over a sample on that edge
  assign o_ready  = i_en & ~i_clr & (~o_valid | i_ready);
  assign accept   = i_valid & o_ready;

  always_comb begin
    dir_next = 2'b00;
    err_next = 1'b0;
    if (state == TRACK) begin
      if (i_grey == prev)
        dir_next = 2'b11;
      else if ($countones(i_grey ^ prev) > 1)
        err_next = 1'b1;
      else if (bin_cur == bin_prev + n'(1))
        dir_next = 2'b01;
      else if (bin_cur == bin_prev - n'(1))
        dir_next = 2'b10;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      prev         <= '0;
      o_valid      <= 1'b0;
      o_bin        <= '0;
      o_dir        <= 2'b00;
      o_step_err   <= 1'b0;
      o_err_sticky <= 1'b0;
    end else begin
      if (accept) begin
        o_valid    <= 1'b1;
        o_bin      <= bin_cur;
        o_dir      <= dir_next;
        o_step_err <= err_next;
      end else if (i_ready) begin
        o_valid    <= 1'b0;
      end

      if (i_clr)
        o_err_sticky <= 1'b0;
      else if (accept && err_next)
        o_err_sticky <= 1'b1;

      if (i_clr || !i_en) begin
        state <= IDLE;
      end else if (accept) begin
        state <= TRACK;
        prev  <= i_grey;
      end
    end
  end

endmodule

// File: tb/tb_grey_decoder_nbit_pipe.sv
// Directed and randomized bench for grey_decoder_nbit_pipe (n=3) against an
// integer-arithmetic reference model of the decode and step-classification rules.
module tb_grey_decoder_nbit_pipe;
  localparam int N   = 3;
  localparam int MOD = 1 << N;

  logic         clk = 1'b0;
  logic         rst, en, valid, rdy, clr;
  logic [N-1:0] grey;
  logic         o_ready, o_valid, o_step_err, o_err_sticky;
  logic [N-1:0] o_bin;
  logic [1:0]   o_dir;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_valid, m_bin, m_dir, m_err, m_sticky, m_have, m_prev;

  grey_decoder_nbit_pipe #(.n(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_grey(grey),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(rdy), .o_bin(o_bin),
    .o_dir(o_dir), .o_step_err(o_step_err), .o_err_sticky(o_err_sticky),
    .i_clr(clr)
  );

  always #5 clk = ~clk;

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < N; s++) b = b ^ (g >> s);
    return b % MOD;
  endfunction

  function automatic int popc(input int x);
    int c = 0;
    for (int s = 0; s < N; s++) c += (x >> s) & 1;
    return c;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_bin = 0; m_dir = 0; m_err = 0; m_sticky = 0; m_have = 0; m_prev = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},  int'(o_valid),      m_valid);
    chk({tag, ".bin"},    int'(o_bin),        m_bin);
    chk({tag, ".dir"},    int'(o_dir),        m_dir);
    chk({tag, ".err"},    int'(o_step_err),   m_err);
    chk({tag, ".sticky"}, int'(o_err_sticky), m_sticky);
  endtask

  // One clock: drive inputs, check o_ready, advance model and DUT, check outputs.
  task automatic cyc(input string tag, input int e, input int v, input int g,
                     input int r, input int c);
    int exp_ready, acc, cur, d;
    en = e[0]; valid = v[0]; grey = N'(g); rdy = r[0]; clr = c[0];
    #1;
    exp_ready = (e != 0 && c == 0 && (m_valid == 0 || r != 0)) ? 1 : 0;
    chk({tag, ".ready"}, int'(o_ready), exp_ready);
    acc = (v != 0 && exp_ready != 0) ? 1 : 0;
    if (acc != 0) begin
      cur = g2b(g);
      m_dir = 0; m_err = 0;
      if (m_have != 0) begin
        d = (cur - g2b(m_prev) + MOD) % MOD;
        if (g == m_prev)               m_dir = 3;
        else if (popc(g ^ m_prev) >= 2) m_err = 1;
        else if (d == 1)               m_dir = 1;
        else if (d == MOD - 1)         m_dir = 2;
      end
      m_valid = 1; m_bin = cur;
      if (m_err != 0) m_sticky = 1;
    end else if (r != 0) begin
      m_valid = 0;
    end
    if (c != 0) m_sticky = 0;
    if (c != 0 || e == 0) m_have = 0;
    else if (acc != 0) begin m_have = 1; m_prev = g; end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    #2 rst = 1'b0;
    #1;
    check_outputs({tag, ".rel"});
  endtask

  initial begin
    int sweep [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int g;
    rst = 1'b1; en = 1'b0; valid = 1'b0; rdy = 1'b0; clr = 1'b0; grey = '0;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // full Gray sweep: binary 0..7, first beat is a restart, then all up
    foreach (sweep[i]) begin
      cyc("sweep", 1, 1, sweep[i], 1, 0);
      chk("sweep.idx", int'(o_bin), i);
      chk("sweep.dirc", int'(o_dir), (i == 0) ? 0 : 1);
    end

    // wrap-around both ways: 7 -> 0 up, 0 -> 7 down
    cyc("wrap_up", 1, 1, 0, 1, 0);
    chk("wrap_up.dirc", int'(o_dir), 1);
    cyc("wrap_dn", 1, 1, 4, 1, 0);
    chk("wrap_dn.dirc", int'(o_dir), 2);

    // illegal two-bit step sets sticky until cleared
    cyc("pre_err", 1, 1, 0, 1, 0);
    cyc("err", 1, 1, 3, 1, 0);
    chk("err.binc", int'(o_bin), 2);
    chk("err.flag", int'(o_step_err), 1);
    cyc("err_hold1", 1, 0, 0, 1, 0);
    cyc("err_hold2", 1, 0, 0, 1, 0);
    chk("err_hold.sticky", int'(o_err_sticky), 1);
    cyc("clr", 1, 1, 1, 1, 1);
    chk("clr.sticky", int'(o_err_sticky), 0);

    // backpressure: beat held, then accept+drain on the same edge
    cyc("bp_acc", 1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc("bp_hold", 1, 1, 3, 0, 0);
      chk("bp_hold.binc", int'(o_bin), 1);
    end
    cyc("bp_b2b", 1, 1, 3, 1, 0);
    chk("bp_b2b.binc", int'(o_bin), 2);
    chk("bp_b2b.validc", int'(o_valid), 1);

    // repeat is a hold; disabling restarts the tracker
    cyc("rep", 1, 1, 3, 1, 0);
    chk("rep.dirc", int'(o_dir), 3);
    cyc("dis", 0, 1, 6, 1, 0);
    cyc("restart", 1, 1, 6, 1, 0);
    chk("restart.dirc", int'(o_dir), 0);
    chk("restart.errc", int'(o_step_err), 0);

    // async reset while a beat is pending
    cyc("pend", 1, 1, 7, 0, 0);
    async_reset("areset");
    cyc("post_rst", 1, 1, 2, 1, 0);
    chk("post_rst.binc", int'(o_bin), 3);
    chk("post_rst.dirc", int'(o_dir), 0);

    // randomized traffic, grey biased toward single-bit neighbours
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0)
        g = m_prev ^ (1 << $urandom_range(0, N - 1));
      else
        g = int'($urandom_range(0, MOD - 1));
      cyc("rand", ($urandom_range(0, 9) != 0) ? 1 : 0, int'($urandom_range(0, 1)), g,
          ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
